// File: rtl/divider_rr_asm_pkg.sv
// divider_rr_asm_pkg: shared state encodings, default widths and divide-by-zero quotient for the restoring divider
package divider_rr_asm_pkg;
   localparam int L_WORD_DEF = 4;
   localparam int L_CNT_DEF = 3;
   localparam logic [31:0] DIV0_QUOTIENT = '1;
   typedef enum logic {S_IDLE = 1'b0, S_RUNNING = 1'b1} state_e;
endpackage

// File: rtl/divider_rr_asm_step.sv
// divider_step: one restoring-division iteration (shift, trial subtract, restore)
module divider_step #(
   parameter int W = 4
) (
   input  logic [W:0]   prem,
   input  logic [W-1:0] quot,
   input  logic [W-1:0] divisor,
   output logic [W:0]   prem_next,
   output logic [W-1:0] quot_next
);
   logic [W:0] shifted;
   logic [W:0] trial;
   logic       unused_prem_msb;
   assign unused_prem_msb = prem[W];
   // borrow-out in trial MSB decides whether the subtraction is kept or restored
   always_comb begin
      shifted   = {prem[W-1:0], quot[W-1]};
      trial     = shifted - {1'b0, divisor};
      prem_next = trial[W] ? shifted : trial;
      quot_next = {quot[W-2:0], ~trial[W]};
   end
endmodule

// File: rtl/divider_rr_asm.sv
// divider_rr_asm: sequential unsigned restoring divider with two-state Start/Ready controller
module divider_rr_asm
   import divider_rr_asm_pkg::*;
#(
   parameter int L_word = L_WORD_DEF,
   parameter int L_cnt  = L_CNT_DEF
) (
   input  logic              clock,
   input  logic              reset_b,
   input  logic [L_word-1:0] word1,
   input  logic [L_word-1:0] word2,
   input  logic              Start,
   output logic [L_word-1:0] quotient,
   output logic [L_word-1:0] remainder,
   output logic              Ready,
   output logic              Div_error
);
   localparam logic [L_word-1:0] QUOT_DIV0 = DIV0_QUOTIENT[L_word-1:0];
   state_e            state_q, state_d;
   logic [L_word-1:0] divisor_q, divisor_d;
   logic [L_word-1:0] quot_q, quot_d;
   logic [L_word:0]   prem_q, prem_d;
   logic [L_cnt-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [L_word:0]   step_prem;
   logic [L_word-1:0] step_quot;
   divider_step #(.W(L_word)) u_step (
      .prem      (prem_q),
      .quot      (quot_q),
      .divisor   (divisor_q),
      .prem_next (step_prem),
      .quot_next (step_quot)
   );
   assign quotient  = quot_q;
   assign remainder = prem_q[L_word-1:0];
   assign Div_error = err_q;
   assign Ready     = (state_q == S_IDLE) && reset_b;
   // controller next state and datapath updates; quotient register doubles as dividend shifter
   always_comb begin
      state_d   = state_q;
      divisor_d = divisor_q;
      quot_d    = quot_q;
      prem_d    = prem_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (word2 == '0) begin
                  quot_d = QUOT_DIV0;
                  prem_d = {1'b0, word1};
                  err_d  = 1'b1;
               end else if (word1 == '0) begin
                  quot_d = '0;
                  prem_d = '0;
                  err_d  = 1'b0;
               end else begin
                  divisor_d = word2;
                  quot_d    = word1;
                  prem_d    = '0;
                  cnt_d     = '0;
                  err_d     = 1'b0;
                  state_d   = S_RUNNING;
               end
            end
         end
         S_RUNNING: begin
            if (cnt_q == L_cnt'(L_word)) begin
               state_d = S_IDLE;
            end else begin
               prem_d = step_prem;
               quot_d = step_quot;
               cnt_d  = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   // state and datapath registers with asynchronous clear
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state_q   <= S_IDLE;
         divisor_q <= '0;
         quot_q    <= '0;
         prem_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         divisor_q <= divisor_d;
         quot_q    <= quot_d;
         prem_q    <= prem_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: tb/tb_divider_rr_asm.sv
// tb_divider_rr_asm: self-checking bench with behavioural divide model and per-cycle compare
module tb_divider_rr_asm;
   localparam int W = 4;
   logic         clock = 1'b0;
   logic         reset_b = 1'b0;
   logic [W-1:0] word1 = '0;
   logic [W-1:0] word2 = '0;
   logic         Start = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         Ready;
   logic         Div_error;
   int           checks = 0;
   int           errors = 0;
   int           busy = 0;
   logic [W-1:0] exp_q = '0;
   logic [W-1:0] exp_r = '0;
   logic         exp_err = 1'b0;

   divider_rr_asm dut (
      .clock     (clock),
      .reset_b   (reset_b),
      .word1     (word1),
      .word2     (word2),
      .Start     (Start),
      .quotient  (quotient),
      .remainder (remainder),
      .Ready     (Ready),
      .Div_error (Div_error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: busy countdown of W+1 cycles, results from plain / and %
   always @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         busy    <= 0;
         exp_q   <= '0;
         exp_r   <= '0;
         exp_err <= 1'b0;
      end else if (busy > 0) begin
         busy <= busy - 1;
      end else if (Start) begin
         if (word2 == 0) begin
            exp_q   <= '1;
            exp_r   <= word1;
            exp_err <= 1'b1;
         end else begin
            exp_q   <= word1 / word2;
            exp_r   <= word1 % word2;
            exp_err <= 1'b0;
            if (word1 != 0) busy <= W + 1;
         end
      end
   end

   // per-cycle compare: Ready always, results whenever idle
   always @(negedge clock) begin
      chk("ready", int'(Ready), int'(busy == 0 && reset_b));
      if (busy == 0 && reset_b) begin
         chk("quotient", int'(quotient), int'(exp_q));
         chk("remainder", int'(remainder), int'(exp_r));
         chk("div_error", int'(Div_error), int'(exp_err));
      end
   end

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
      int n;
      @(negedge clock);
      word1 = a;
      word2 = b;
      Start = 1'b1;
      @(negedge clock);
      Start = 1'b0;
      n = 0;
      while (!Ready && n < 20) begin
         if (scramble) begin
            word1 = W'($urandom);
            word2 = W'($urandom);
            Start = 1'($urandom);
         end
         @(negedge clock);
         n++;
      end
      Start = 1'b0;
      chk("busy_cycles", n, (a != 0 && b != 0) ? W + 1 : 0);
      if (b != 0) begin
         chk("prop_qd_plus_r", int'(quotient) * int'(b) + int'(remainder), int'(a));
         chk("prop_r_lt_d", int'(remainder < b), 1);
      end else begin
         chk("prop_div0_err", int'(Div_error), 1);
      end
   endtask

   initial begin
      #1;
      chk("reset_ready", int'(Ready), 0);
      chk("reset_quotient", int'(quotient), 0);
      chk("reset_remainder", int'(remainder), 0);
      chk("reset_err", int'(Div_error), 0);
      @(negedge clock);
      reset_b = 1'b1;
      @(negedge clock);
      chk("idle_ready", int'(Ready), 1);
      op(4'd13, 4'd3, 0);
      chk("lit_13_3_q", int'(quotient), 4);
      chk("lit_13_3_r", int'(remainder), 1);
      chk("lit_13_3_e", int'(Div_error), 0);
      op(4'd5, 4'd9, 0);
      chk("lit_5_9_q", int'(quotient), 0);
      chk("lit_5_9_r", int'(remainder), 5);
      op(4'd15, 4'd1, 0);
      chk("lit_15_1_q", int'(quotient), 15);
      chk("lit_15_1_r", int'(remainder), 0);
      op(4'd7, 4'd0, 0);
      chk("lit_7_0_q", int'(quotient), 15);
      chk("lit_7_0_r", int'(remainder), 7);
      chk("lit_7_0_e", int'(Div_error), 1);
      op(4'd6, 4'd2, 0);
      chk("lit_6_2_q", int'(quotient), 3);
      chk("lit_6_2_r", int'(remainder), 0);
      chk("lit_6_2_e", int'(Div_error), 0);
      op(4'd0, 4'd5, 0);
      chk("lit_0_5_q", int'(quotient), 0);
      chk("lit_0_5_r", int'(remainder), 0);
      // Start held high through part of the run must be ignored
      @(negedge clock);
      word1 = 4'd9;
      word2 = 4'd2;
      Start = 1'b1;
      repeat (4) @(negedge clock);
      Start = 1'b0;
      word1 = 4'd1;
      word2 = 4'd1;
      repeat (3) @(negedge clock);
      chk("held_start_ready", int'(Ready), 1);
      chk("lit_9_2_q", int'(quotient), 4);
      chk("lit_9_2_r", int'(remainder), 1);
      // asynchronous reset in the middle of 14/3
      @(negedge clock);
      word1 = 4'd14;
      word2 = 4'd3;
      Start = 1'b1;
      @(negedge clock);
      Start = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #2;
      reset_b = 1'b0;
      #1;
      chk("abort_ready", int'(Ready), 0);
      chk("abort_quotient", int'(quotient), 0);
      chk("abort_remainder", int'(remainder), 0);
      chk("abort_err", int'(Div_error), 0);
      @(negedge clock);
      reset_b = 1'b1;
      op(4'd14, 4'd3, 0);
      chk("lit_14_3_q", int'(quotient), 4);
      chk("lit_14_3_r", int'(remainder), 2);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            op(W'(a), W'(b), 0);
      for (int i = 0; i < 150; i++) begin
         op(W'($urandom), W'($urandom), 1);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
